// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core. One ALU and one unified req/ready memory port
// are shared across the FETCH/DECODE/EXEC/MEM/WB states. Illegal opcodes halt
// the core until reset.
module multicycle_cpu #(
  parameter int          MEM_ADDR_W = 12,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic                  halted,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08, FN_ADD  = 6'h20, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t             state_q;
  logic [31:0]        pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [CNT_W-1:0]   instret_q;
  logic [31:0]        regs_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm, zext_imm, jtarget, rf_a, rf_b;
  logic [31:0] alu_d, wb_data_d;
  logic [4:0]  wb_dst_d;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'h0000, ir_q[15:0]};
  assign jtarget  = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign rf_a     = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rf_b     = (rt == 5'd0) ? 32'h0 : regs_q[rt];

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_RTYPE: is_legal = (f == FN_ADD) || (f == FN_SUB) || (f == FN_SLT) || (f == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: is_legal = 1'b1;
      default:  is_legal = 1'b0;
    endcase
  endfunction

  // Shared ALU result used in EXEC for arithmetic and address generation.
  always_comb begin
    alu_d = 32'h0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_d = a_q + b_q;
          FN_SUB:  alu_d = a_q - b_q;
          FN_SLT:  alu_d = {31'h0, ($signed(a_q) < $signed(b_q))};
          default: alu_d = 32'h0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_d = a_q + sext_imm;
      OP_XORI:               alu_d = a_q ^ zext_imm;
      default:               alu_d = 32'h0;
    endcase
  end

  // Writeback destination and data; r0 as destination means no write.
  always_comb begin
    wb_dst_d  = 5'd0;
    wb_data_d = alu_q;
    case (op)
      OP_RTYPE:         wb_dst_d = rd;
      OP_ADDI, OP_XORI: wb_dst_d = rt;
      OP_LW: begin
        wb_dst_d  = rt;
        wb_data_d = mdr_q;
      end
      default:          wb_dst_d = 5'd0;
    endcase
  end

  // Main control FSM with datapath registers and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_q     <= 32'h0;
      mdr_q     <= 32'h0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rf_a;
          b_q     <= rf_b;
          alu_q   <= pc_q + {sext_imm[29:0], 2'b00};
          state_q <= is_legal(op, funct) ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          case (op)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc_q      <= a_q;
                instret_q <= instret_q + CNT_W'(1);
                state_q   <= S_FETCH;
              end else begin
                alu_q   <= alu_d;
                state_q <= S_WB;
              end
            end
            OP_ADDI, OP_XORI: begin
              alu_q   <= alu_d;
              state_q <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_q   <= alu_d;
              state_q <= S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              if ((a_q == b_q) == (op == OP_BEQ)) pc_q <= alu_q;
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end
            OP_J, OP_JAL: begin
              pc_q <= jtarget;
              if (op == OP_JAL) regs_q[31] <= pc_q;
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end
            default: state_q <= S_HALT;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dst_d != 5'd0) regs_q[wb_dst_d] <= wb_data_d;
          instret_q <= instret_q + CNT_W'(1);
          state_q   <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Memory port decoded from the registered state; reset blanks it at once so
  // an access in flight is abandoned and no write escapes.
  assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = !reset && (state_q == S_MEM) && (op == OP_SW);
  assign mem_addr  = reset                  ? '0 :
                     (state_q == S_FETCH)   ? pc_q[MEM_ADDR_W+1:2] :
                     (state_q == S_MEM)     ? alu_q[MEM_ADDR_W+1:2] : '0;
  assign mem_wdata = mem_we ? b_q : 32'h0;

  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs in a word-addressed memory
// model with a programmable number of wait cycles per access.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc, instret;

  logic [31:0] mem [0:4095];
  logic [7:0]  wait_n = 8'd0;
  logic [7:0]  wcnt;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = 12'h0;
  logic [31:0] ld_data = 32'h0;

  int sw_cyc;
  logic [11:0] sw_addr;
  logic [31:0] sw_data;
  logic        sw_unstable;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  multicycle_cpu #(.MEM_ADDR_W(12), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  assign mem_ready = (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr];

  // Wait-state counter: restarts for every access.
  always @(posedge clk) begin
    if (reset || !mem_req || mem_ready) wcnt <= 8'd0;
    else                                wcnt <= wcnt + 8'd1;
  end

  // Memory array: program loading while in reset, otherwise DUT stores.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
  end

  // Store monitor: records the first cycle of a store and flags any change.
  always @(negedge clk) begin
    if (reset) begin
      sw_cyc      <= 0;
      sw_unstable <= 1'b0;
    end else if (mem_req && mem_we) begin
      if (sw_cyc == 0) begin
        sw_addr <= mem_addr;
        sw_data <= mem_wdata;
      end else if (mem_addr != sw_addr || mem_wdata != sw_data) begin
        sw_unstable <= 1'b1;
      end
      sw_cyc <= sw_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    reset   = 1'b1;
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
  endtask

  task automatic release_reset();
    @(negedge clk);
    ld_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    // ALU program, zero-wait memory.
    wait_n = 8'd0;
    poke(12'h0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(12'h1, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    poke(12'h2, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    poke(12'h3, enc_r(5'd2, 5'd1, 5'd4, 6'h22));
    poke(12'h4, enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
    poke(12'h5, HALT_W);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_instret", instret, 32'h0);
    release_reset();
    tick(19);
    chk("alu_instret_19", instret, 32'd4);
    tick(1);
    chk("alu_instret_20", instret, 32'd5);
    chk("alu_pc_20", pc, 32'h14);
    chk("alu_r3_add", dut.regs_q[3], 32'h2);
    chk("alu_r4_sub", dut.regs_q[4], 32'hFFFFFFF8);
    chk("alu_r5_slt", dut.regs_q[5], 32'h1);

    // Store/load with two wait cycles on every access.
    wait_n = 8'd2;
    poke(12'h0, enc_i(6'h08, 5'd0, 5'd1, 16'h40));
    poke(12'h1, enc_i(6'h2B, 5'd1, 5'd1, 16'd8));
    poke(12'h2, enc_i(6'h23, 5'd1, 5'd6, 16'd8));
    poke(12'h3, HALT_W);
    poke(12'h12, 32'h0);
    release_reset();
    tick(40);
    chk("sw_cycles", 32'(sw_cyc), 32'd3);
    chk("sw_addr", {20'h0, sw_addr}, 32'h12);
    chk("sw_wdata", sw_data, 32'h40);
    chk("sw_stable", {31'h0, sw_unstable}, 32'h0);
    chk("sw_mem_word", mem[12'h12], 32'h40);
    chk("lw_r6", dut.regs_q[6], 32'h40);
    chk("ldst_instret", instret, 32'd3);
    chk("ldst_halted", {31'h0, halted}, 32'h1);

    // Taken BEQ.
    wait_n = 8'd0;
    poke(12'h0, enc_i(6'h04, 5'd0, 5'd0, 16'd2));
    poke(12'h1, HALT_W);
    poke(12'h3, HALT_W);
    release_reset();
    tick(2);
    chk("beq_pc_2cyc", pc, 32'h4);
    tick(1);
    chk("beq_pc_3cyc", pc, 32'hC);
    chk("beq_instret", instret, 32'd1);

    // Not-taken BNE.
    poke(12'h0, enc_i(6'h05, 5'd0, 5'd0, 16'd2));
    release_reset();
    tick(2);
    chk("bne_instret_2cyc", instret, 32'd0);
    tick(1);
    chk("bne_pc", pc, 32'h4);
    chk("bne_instret", instret, 32'd1);

    // JAL then JR back.
    poke(12'h0, enc_i(6'h08, 5'd0, 5'd7, 16'd1));
    poke(12'h1, enc_i(6'h08, 5'd0, 5'd8, 16'd2));
    poke(12'h2, enc_j(6'h03, 26'h10));
    poke(12'h3, HALT_W);
    poke(12'h10, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    release_reset();
    tick(11);
    chk("jal_r31", dut.regs_q[31], 32'hC);
    chk("jal_pc", pc, 32'h40);
    tick(3);
    chk("jr_pc", pc, 32'hC);
    chk("jr_instret", instret, 32'd4);
    tick(2);
    chk("jr_then_halt", {31'h0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h10);
    chk("halt_mem_req", {31'h0, mem_req}, 32'h0);

    // r0 discard, signed overflow wrap, SLT on negative, XORI zero-extend.
    poke(12'h0, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
    poke(12'h1, enc_r(5'd0, 5'd0, 5'd9, 6'h20));
    poke(12'h2, enc_i(6'h08, 5'd0, 5'd1, 16'h7FFF));
    poke(12'h3, enc_i(6'h23, 5'd0, 5'd2, 16'h0100));
    poke(12'h4, enc_r(5'd1, 5'd2, 5'd1, 6'h20));
    poke(12'h5, enc_r(5'd1, 5'd0, 5'd10, 6'h2A));
    poke(12'h6, enc_r(5'd1, 5'd2, 5'd1, 6'h20));
    poke(12'h7, enc_i(6'h0E, 5'd2, 5'd11, 16'hFFFF));
    poke(12'h8, HALT_W);
    poke(12'h40, 32'h7FFFFFFF);
    release_reset();
    tick(50);
    chk("r0_reg", dut.regs_q[0], 32'h0);
    chk("r0_reads_zero", dut.regs_q[9], 32'h0);
    chk("ovf_slt_neg", dut.regs_q[10], 32'h1);
    chk("ovf_wrap_r1", dut.regs_q[1], 32'h00007FFD);
    chk("xori_zext", dut.regs_q[11], 32'h7FFF0000);
    chk("ovf_instret", instret, 32'd8);

    // Illegal opcode halts after DECODE.
    poke(12'h0, HALT_W);
    release_reset();
    tick(1);
    chk("illegal_not_yet", {31'h0, halted}, 32'h0);
    tick(1);
    chk("illegal_halted", {31'h0, halted}, 32'h1);
    chk("illegal_pc", pc, 32'h4);
    chk("illegal_instret", instret, 32'd0);
    tick(5);
    chk("illegal_stays", {31'h0, halted}, 32'h1);
    chk("illegal_no_req", {31'h0, mem_req}, 32'h0);

    // Reset in the middle of a stalled store.
    wait_n = 8'd3;
    poke(12'h0, enc_i(6'h08, 5'd0, 5'd1, 16'h40));
    poke(12'h1, enc_i(6'h2B, 5'd1, 5'd1, 16'd0));
    poke(12'h2, HALT_W);
    poke(12'h10, 32'hDEADBEEF);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("midwr_store_seen", {31'h0, found}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midwr_req", {31'h0, mem_req}, 32'h0);
    chk("midwr_we", {31'h0, mem_we}, 32'h0);
    chk("midwr_addr", {20'h0, mem_addr}, 32'h0);
    chk("midwr_wdata", mem_wdata, 32'h0);
    tick(3);
    chk("midwr_no_write", mem[12'h10], 32'hDEADBEEF);
    chk("midwr_pc", pc, 32'h0);
    chk("midwr_instret", instret, 32'd0);
    reset = 1'b0;
    #1;
    chk("restart_req", {31'h0, mem_req}, 32'h1);
    chk("restart_addr", {20'h0, mem_addr}, 32'h0);
    @(negedge clk);
    tick(3);
    chk("restart_pc", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
